// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between the two writeback requesters and the register file.
// Groups both valid/ready request channels, the clear-sweep controls and the
// registered register-file write port.
//   master : requester side (drives requests and clear_req, sees ready/write port)
//   slave  : arbiter side (sees requests, drives ready, clear_busy and write port)
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  clear_req;
  logic                  clear_busy;
  logic                  write;
  logic [ADDR_WIDTH-1:0] writeAddress;
  logic [DATA_WIDTH-1:0] writeData;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clear_req,
    input  req0_ready, req1_ready, clear_busy,
    input  write, writeAddress, writeData
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clear_req,
    output req0_ready, req1_ready, clear_busy,
    output write, writeAddress, writeData
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between port 0 (ALU writeback)
// and port 1 (load writeback) using round-robin arbitration, and sequences a
// clear sweep that writes CLEAR_VALUE to every register, one per cycle.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave side of regfile_write_arbiter_if (requests, ready,
//           clear_req/clear_busy, registered write/writeAddress/writeData)
module regfile_write_arbiter #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 3,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input logic                    clock,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, cnt_n;
  logic                  last_grant, last_grant_n;
  logic                  busy, busy_n;
  logic                  wr, wr_n;
  logic [ADDR_WIDTH-1:0] waddr, waddr_n;
  logic [DATA_WIDTH-1:0] wdata, wdata_n;
  logic                  rdy0, rdy1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      busy       <= 1'b0;
      wr         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last_grant <= last_grant_n;
      busy       <= busy_n;
      wr         <= wr_n;
      waddr      <= waddr_n;
      wdata      <= wdata_n;
    end
  end

  always_comb begin
    rdy0         = 1'b0;
    rdy1         = 1'b0;
    state_n      = state;
    cnt_n        = cnt;
    last_grant_n = last_grant;
    busy_n       = busy;
    wr_n         = 1'b0;
    waddr_n      = waddr;
    wdata_n      = wdata;

    case (state)
      IDLE: begin
        // A clear request blocks both ports for this cycle.
        if (!bus.clear_req) begin
          if (bus.req0_valid && bus.req1_valid) begin
            rdy0 = last_grant;
            rdy1 = !last_grant;
          end else begin
            rdy0 = bus.req0_valid;
            rdy1 = bus.req1_valid;
          end
        end

        if (bus.clear_req) begin
          state_n = CLEAR;
          busy_n  = 1'b1;
          cnt_n   = ADDR_WIDTH'(1);
          wr_n    = 1'b1;
          waddr_n = '0;
          wdata_n = CLEAR_VALUE;
        end else if (rdy0) begin
          wr_n         = 1'b1;
          waddr_n      = bus.req0_addr;
          wdata_n      = bus.req0_data;
          last_grant_n = 1'b0;
        end else if (rdy1) begin
          wr_n         = 1'b1;
          waddr_n      = bus.req1_addr;
          wdata_n      = bus.req1_data;
          last_grant_n = 1'b1;
        end
      end

      CLEAR: begin
        wr_n    = 1'b1;
        waddr_n = cnt;
        wdata_n = CLEAR_VALUE;
        cnt_n   = cnt + ADDR_WIDTH'(1);
        // Busy drops together with the final sweep write.
        if (cnt == ADDR_WIDTH'(NUM_REGS - 1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.req0_ready   = rdy0;
  assign bus.req1_ready   = rdy1;
  assign bus.clear_busy   = busy;
  assign bus.write        = wr;
  assign bus.writeAddress = waddr;
  assign bus.writeData    = wdata;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clock;
  logic reset;
  int   vecs;
  int   errs;

  logic [DW-1:0] rf [0:7];

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_write_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CLEAR_VALUE(16'h0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file behind the write port.
  always @(posedge clock)
    if (bus.write === 1'b1) rf[bus.writeAddress] <= bus.writeData;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.clear_req  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Writes val to every register through port 0, then lets the last write commit.
  task automatic preload(input logic [DW-1:0] val);
    for (int unsigned a = 0; a < 8; a++) begin
      bus.req0_valid = 1'b1;
      bus.req0_addr  = AW'(a);
      bus.req0_data  = val;
      tick();
    end
    bus.req0_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    vecs++;
    if (bus.write !== 1'b0 || bus.writeAddress !== 3'd0 || bus.writeData !== 16'h0 || bus.clear_busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_outputs: write=%b addr=%0d data=%0h busy=%b, want 0 0 0 0",
               bus.write, bus.writeAddress, bus.writeData, bus.clear_busy);
    end
    vecs++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready: r0=%b r1=%b, want 0 0", bus.req0_ready, bus.req1_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd3; bus.req0_data = 16'h00A5;
    #1;
    vecs++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errs++;
      $display("FAIL single_ready: r0=%b r1=%b, want 1 0", bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    vecs++;
    if (bus.write !== 1'b1 || bus.writeAddress !== 3'd3 || bus.writeData !== 16'h00A5) begin
      errs++;
      $display("FAIL single_write: write=%b addr=%0d data=%0h, want 1 3 a5",
               bus.write, bus.writeAddress, bus.writeData);
    end
    tick();
    vecs++;
    if (bus.write !== 1'b0 || bus.writeAddress !== 3'd3 || bus.writeData !== 16'h00A5) begin
      errs++;
      $display("FAIL single_hold: write=%b addr=%0d data=%0h, want 0 3 a5",
               bus.write, bus.writeAddress, bus.writeData);
    end
    vecs++;
    if (rf[3] !== 16'h00A5) begin
      errs++;
      $display("FAIL single_rf: rf[3]=%0h, want a5", rf[3]);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd1; bus.req0_data = 16'h0011;
    bus.req1_valid = 1'b1; bus.req1_addr = 3'd2; bus.req1_data = 16'h0022;
    #1;
    vecs++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errs++;
      $display("FAIL conflict_c0: r0=%b r1=%b, want 1 0", bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    #1;
    vecs++;
    if (bus.write !== 1'b1 || bus.writeAddress !== 3'd1 || bus.writeData !== 16'h0011 || bus.req1_ready !== 1'b1) begin
      errs++;
      $display("FAIL conflict_c1: write=%b addr=%0d data=%0h r1=%b, want 1 1 11 1",
               bus.write, bus.writeAddress, bus.writeData, bus.req1_ready);
    end
    tick();
    bus.req1_valid = 1'b0;
    vecs++;
    if (bus.write !== 1'b1 || bus.writeAddress !== 3'd2 || bus.writeData !== 16'h0022) begin
      errs++;
      $display("FAIL conflict_c2: write=%b addr=%0d data=%0h, want 1 2 22",
               bus.write, bus.writeAddress, bus.writeData);
    end
    tick();
    vecs++;
    if (rf[1] !== 16'h0011 || rf[2] !== 16'h0022 || bus.write !== 1'b0) begin
      errs++;
      $display("FAIL conflict_rf: rf1=%0h rf2=%0h write=%b, want 11 22 0", rf[1], rf[2], bus.write);
    end
  endtask

  // last_grant is 1 on entry, so grants go 0,1,0,1,0,1.
  task automatic test_back_to_back();
    int unsigned n0 = 0;
    int unsigned n1 = 0;
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd4;
    bus.req1_valid = 1'b1; bus.req1_addr = 3'd5;
    for (int unsigned i = 0; i < 6; i++) begin
      logic          exp_p;
      logic [DW-1:0] exp_d;
      exp_p = i[0];
      bus.req0_data = DW'(16'h1000 + n0);
      bus.req1_data = DW'(16'h2000 + n1);
      exp_d = exp_p ? bus.req1_data : bus.req0_data;
      #1;
      vecs++;
      if (bus.req0_ready !== !exp_p || bus.req1_ready !== exp_p) begin
        errs++;
        $display("FAIL contention_grant[%0d]: r0=%b r1=%b, want %b %b",
                 i, bus.req0_ready, bus.req1_ready, !exp_p, exp_p);
      end
      tick();
      vecs++;
      if (bus.write !== 1'b1 || bus.writeAddress !== (exp_p ? 3'd5 : 3'd4) || bus.writeData !== exp_d) begin
        errs++;
        $display("FAIL contention_write[%0d]: write=%b addr=%0d data=%0h, want 1 %0d %0h",
                 i, bus.write, bus.writeAddress, bus.writeData, exp_p ? 5 : 4, exp_d);
      end
      if (exp_p) n1++; else n0++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_clear_sweep();
    preload(16'hFFFF);
    bus.clear_req  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd6; bus.req0_data = 16'h0BEE;
    #1;
    vecs++;
    if (bus.req0_ready !== 1'b0 || bus.clear_busy !== 1'b0) begin
      errs++;
      $display("FAIL clear_block: r0=%b busy=%b, want 0 0", bus.req0_ready, bus.clear_busy);
    end
    tick();
    bus.clear_req = 1'b0;
    #1;
    vecs++;
    if (bus.write !== 1'b1 || bus.writeAddress !== 3'd0 || bus.writeData !== 16'h0 ||
        bus.clear_busy !== 1'b1 || bus.req0_ready !== 1'b0) begin
      errs++;
      $display("FAIL clear_first: write=%b addr=%0d data=%0h busy=%b r0=%b, want 1 0 0 1 0",
               bus.write, bus.writeAddress, bus.writeData, bus.clear_busy, bus.req0_ready);
    end
    for (int unsigned k = 1; k < 8; k++) begin
      tick();
      vecs++;
      if (bus.write !== 1'b1 || bus.writeAddress !== AW'(k) || bus.writeData !== 16'h0 ||
          bus.clear_busy !== (k < 7) || bus.req0_ready !== (k == 7)) begin
        errs++;
        $display("FAIL clear_step[%0d]: write=%b addr=%0d data=%0h busy=%b r0=%b, want 1 %0d 0 %b %b",
                 k, bus.write, bus.writeAddress, bus.writeData, bus.clear_busy, bus.req0_ready,
                 k, k < 7, k == 7);
      end
    end
    tick();
    bus.req0_valid = 1'b0;
    vecs++;
    if (bus.write !== 1'b1 || bus.writeAddress !== 3'd6 || bus.writeData !== 16'h0BEE) begin
      errs++;
      $display("FAIL clear_resume: write=%b addr=%0d data=%0h, want 1 6 bee",
               bus.write, bus.writeAddress, bus.writeData);
    end
    tick();
    for (int unsigned a = 0; a < 8; a++) begin
      vecs++;
      if (rf[a] !== ((a == 6) ? 16'h0BEE : 16'h0000)) begin
        errs++;
        $display("FAIL clear_rf[%0d]: got %0h, want %0h", a, rf[a], (a == 6) ? 16'h0BEE : 16'h0);
      end
    end
  endtask

  task automatic test_clear_ignored();
    int unsigned nwr = 0;
    bus.clear_req = 1'b1;
    tick();
    // Outputs now show sweep write 0; index j = sweep write number.
    for (int unsigned j = 0; j < 12; j++) begin
      bus.clear_req = (j == 3);
      if (bus.write === 1'b1) nwr++;
      if (j == 7) begin
        vecs++;
        if (bus.write !== 1'b1 || bus.writeAddress !== 3'd7 || bus.clear_busy !== 1'b0) begin
          errs++;
          $display("FAIL ignore_last: write=%b addr=%0d busy=%b, want 1 7 0",
                   bus.write, bus.writeAddress, bus.clear_busy);
        end
      end
      tick();
    end
    bus.clear_req = 1'b0;
    vecs++;
    if (nwr != 8) begin
      errs++;
      $display("FAIL ignore_count: writes=%0d, want 8", nwr);
    end
  endtask

  task automatic test_reset_mid_sweep();
    preload(16'hFFFF);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    tick();
    tick();
    vecs++;
    if (bus.writeAddress !== 3'd2 || bus.write !== 1'b1) begin
      errs++;
      $display("FAIL midrst_pre: write=%b addr=%0d, want 1 2", bus.write, bus.writeAddress);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vecs++;
    if (bus.write !== 1'b0 || bus.clear_busy !== 1'b0) begin
      errs++;
      $display("FAIL midrst_out: write=%b busy=%b, want 0 0", bus.write, bus.clear_busy);
    end
    tick();
    for (int unsigned a = 0; a < 8; a++) begin
      vecs++;
      if (rf[a] !== ((a < 3) ? 16'h0000 : 16'hFFFF)) begin
        errs++;
        $display("FAIL midrst_rf[%0d]: got %0h, want %0h", a, rf[a], (a < 3) ? 16'h0 : 16'hFFFF);
      end
    end
  endtask

  initial begin
    vecs  = 0;
    errs  = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_conflict();
    test_back_to_back();
    test_clear_sweep();
    test_clear_ignored();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
